alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
//
// PURPOSE
//   Shares the single ALU datapath (aluctrl + ALU) between two requesters:
//   req0 = execute stage, req1 = branch/address unit.
//   Arbitrates valid/ready requests, muxes aluop/funct/operands into the ALU,
//   registers the ALU result and returns it to the winner via a valid/ready response.
//   One transaction outstanding; sustained throughput 1 op/cycle with response pass-through.
//
// PARAMETERS
//   XLEN   32  operand/result width
//   RR_EN  1   1 = round-robin between req0/req1; 0 = fixed priority, req0 always wins
//
// PORTS
//   i_clk          in   1     clock, rising edge
//   i_rst          in   1     synchronous reset, active-high
//   i_reqN_valid   in   1     request N valid (N = 0,1)
//   o_reqN_ready   out  1     request N accepted this cycle
//   i_reqN_aluop   in   2     aluop to aluctrl (00 ADD, 01 SLTU, 10 funct)
//   i_reqN_funct   in   4     funct field for aluop = 10
//   i_reqN_a/b     in   XLEN  operands
//   o_rspN_valid   out  1     result held for requester N
//   i_rspN_ready   in   1     requester N consumes result
//   o_rsp_result   out  XLEN  registered ALU result (shared; qualified by o_rspN_valid)
//   o_alu_aluop    out  2     to aluctrl
//   o_alu_funct    out  4     to aluctrl
//   o_alu_a/b      out  XLEN  to ALU operands
//   i_alu_result   in   XLEN  combinational ALU result
//
// BEHAVIOUR
//   State: IDLE / RESP (tracks owner of held result) + last_grant pointer.
//   Reset: state = IDLE; o_rspN_valid = 0; o_rsp_result = 0; last_grant = 1 (req0 wins first).
//   o_reqN_ready is 0 during reset.
//   Grant (combinational):
//     RR_EN = 1: both valid -> requester != last_grant; else the one valid.
//     RR_EN = 0: req0 if valid, else req1.
//   Slot free = (state == IDLE) | (RESP & rsp_valid & rsp_ready of the current owner).
//   o_reqN_ready = slot free & grant == N & i_reqN_valid.
//     At most one ready high per cycle.
//   On accept (valid & ready), in the same cycle:
//     - the ALU ports carry the winner's aluop/funct/a/b;
//     - at the edge, o_rsp_result <= i_alu_result, owner <= N, o_rspN_valid <= 1,
//       last_grant <= N, state <= RESP.
//     Latency is 1 cycle from accept to o_rspN_valid.
//   No accept: ALU ports are driven to 0 (aluop 00, funct 0, a = b = 0).
//   RESP: o_rsp_result and the owner's valid are held stable until i_rspN_ready.
//     - rsp handshake with no new accept -> IDLE, valid drops next cycle.
//     - rsp handshake plus new accept in the same cycle -> stays RESP with the new
//       owner/result (back-to-back, no bubble).
//   i_rspN_ready while o_rspN_valid = 0 is ignored.
//   Requester rule: valid and payload held until ready. The arbiter never drops a
//   pending request; grant may move only when a different requester is accepted.
//   Reset mid-op (in RESP or during accept): outstanding result discarded; all outputs
//   return to reset values the cycle after i_rst.
//
// TESTING
//   1. Reset, req0 ADD a=5 b=7 -> ready0 same cycle; next cycle rsp0_valid=1, result=12; rsp1_valid=0.
//   2. Both valid every cycle, rsp ready tied 1, RR_EN=1 -> grants alternate 0,1,0,1; one result per cycle.
//   3. RR_EN=0, both valid -> req1 never granted while req0 valid;
//      req1 granted in the cycle req0 drops valid.
//   4. req1 SLTU a=3 b=9, i_rsp1_ready=0 for 4 cycles -> result=1 held stable; both readies 0;
//      accept resumes the cycle rsp1_ready rises.
//   5. req0 funct mode (aluop=10, funct=0000) a=0xFFFFFFFF b=1 -> result 0 (wrap); ALU ports 0 when idle.
//   6. i_rst asserted while rsp0_valid=1 -> rsp0_valid=0 and result=0 next cycle;
//      first grant after reset goes to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : two-requester valid/ready arbiter sharing one ALU datapath
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [1:0]      i_req0_aluop,
  input  logic [3:0]      i_req0_funct,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [1:0]      i_req1_aluop,
  input  logic [3:0]      i_req1_funct,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req1_b,
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  output logic [XLEN-1:0] o_rsp_result,
  output logic [1:0]      o_alu_aluop,
  output logic [3:0]      o_alu_funct,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  input  logic [XLEN-1:0] i_alu_result
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_owner;
  logic            r_last_grant;
  logic [XLEN-1:0] r_rsp_result;

  logic            w_rsp_hs;
  logic            w_slot_free;
  logic            w_grant;
  logic            w_accept0;
  logic            w_accept1;
  logic            w_accept;

  assign w_rsp_hs    = (r_state == RESP) & (r_owner ? i_rsp1_ready : i_rsp0_ready);
  assign w_slot_free = ((r_state == IDLE) | w_rsp_hs) & ~i_rst;

  // Round-robin only matters when both request; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (RR_EN) begin
      if (i_req0_valid & i_req1_valid) w_grant = ~r_last_grant;
      else                             w_grant = i_req1_valid;
    end else begin
      w_grant = ~i_req0_valid & i_req1_valid;
    end
  end

  assign w_accept0 = w_slot_free & ~w_grant & i_req0_valid;
  assign w_accept1 = w_slot_free &  w_grant & i_req1_valid;
  assign w_accept  = w_accept0 | w_accept1;

  assign o_req0_ready = w_accept0;
  assign o_req1_ready = w_accept1;

  always_comb begin
    o_alu_aluop = 2'b00;
    o_alu_funct = 4'b0000;
    o_alu_a     = '0;
    o_alu_b     = '0;
    if (w_accept0) begin
      o_alu_aluop = i_req0_aluop;
      o_alu_funct = i_req0_funct;
      o_alu_a     = i_req0_a;
      o_alu_b     = i_req0_b;
    end else if (w_accept1) begin
      o_alu_aluop = i_req1_aluop;
      o_alu_funct = i_req1_funct;
      o_alu_a     = i_req1_a;
      o_alu_b     = i_req1_b;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)      w_state_nxt = RESP;
    else if (w_rsp_hs) w_state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner      <= w_accept1;
        r_last_grant <= w_accept1;
        r_rsp_result <= i_alu_result;
      end
    end
  end

  assign o_rsp0_valid = (r_state == RESP) & ~r_owner;
  assign o_rsp1_valid = (r_state == RESP) &  r_owner;
  assign o_rsp_result = r_rsp_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed bench; one round-robin and one fixed-priority DUT
// Revision       : 1.0
// ============================================================================
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rr0, rr1;
  logic [1:0]  op0, op1;
  logic [3:0]  f0, f1;
  logic [31:0] a0, b0, a1, b1;

  logic        r_rdy0, r_rdy1, r_vld0, r_vld1;
  logic [31:0] r_res, r_alua, r_alub, r_alur;
  logic [1:0]  r_aluop;
  logic [3:0]  r_alufn;

  logic        p_rdy0, p_rdy1, p_vld0, p_vld1;
  logic [31:0] p_res, p_alua, p_alub, p_alur;
  logic [1:0]  p_aluop;
  logic [3:0]  p_alufn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [3:0] fn,
                                        input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return {31'b0, (a < b)};
      2'b10:   return (fn == 4'b0000) ? a + b : a - b;
      default: return a & b;
    endcase
  endfunction

  assign r_alur = alu_f(r_aluop, r_alufn, r_alua, r_alub);
  assign p_alur = alu_f(p_aluop, p_alufn, p_alua, p_alub);

  alu_arbiter #(.XLEN(32), .RR_EN(1'b1)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(r_rdy0), .i_req0_aluop(op0), .i_req0_funct(f0),
    .i_req0_a(a0), .i_req0_b(b0),
    .i_req1_valid(v1), .o_req1_ready(r_rdy1), .i_req1_aluop(op1), .i_req1_funct(f1),
    .i_req1_a(a1), .i_req1_b(b1),
    .o_rsp0_valid(r_vld0), .i_rsp0_ready(rr0), .o_rsp1_valid(r_vld1), .i_rsp1_ready(rr1),
    .o_rsp_result(r_res), .o_alu_aluop(r_aluop), .o_alu_funct(r_alufn),
    .o_alu_a(r_alua), .o_alu_b(r_alub), .i_alu_result(r_alur)
  );

  alu_arbiter #(.XLEN(32), .RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(p_rdy0), .i_req0_aluop(op0), .i_req0_funct(f0),
    .i_req0_a(a0), .i_req0_b(b0),
    .i_req1_valid(v1), .o_req1_ready(p_rdy1), .i_req1_aluop(op1), .i_req1_funct(f1),
    .i_req1_a(a1), .i_req1_b(b1),
    .o_rsp0_valid(p_vld0), .i_rsp0_ready(rr0), .o_rsp1_valid(p_vld1), .i_rsp1_ready(rr1),
    .o_rsp_result(p_res), .o_alu_aluop(p_aluop), .o_alu_funct(p_alufn),
    .o_alu_a(p_alua), .o_alu_b(p_alub), .i_alu_result(p_alur)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic exp_g;
    rst = 1'b1; v0 = 1'b1; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    op0 = 2'b00; f0 = 4'd0; a0 = 32'd5;   b0 = 32'd7;
    op1 = 2'b00; f1 = 4'd0; a1 = 32'd100; b1 = 32'd1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready0", {31'b0, r_rdy0}, 32'd0);
    chk("rst_rsp0_valid", {31'b0, r_vld0}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, r_vld1}, 32'd0);
    chk("rst_result", r_res, 32'd0);

    // 1: single ADD
    rst = 1'b0; #1;
    chk("t1_ready0", {31'b0, r_rdy0}, 32'd1);
    chk("t1_ready1", {31'b0, r_rdy1}, 32'd0);
    chk("t1_alu_a", r_alua, 32'd5);
    chk("t1_alu_b", r_alub, 32'd7);
    cyc(); v0 = 1'b0; #1;
    chk("t1_rsp0_valid", {31'b0, r_vld0}, 32'd1);
    chk("t1_rsp1_valid", {31'b0, r_vld1}, 32'd0);
    chk("t1_result", r_res, 32'd12);
    rr0 = 1'b1;
    cyc(); rr0 = 1'b0; #1;
    chk("t1_idle_valid", {31'b0, r_vld0}, 32'd0);

    // 2 & 3: both valid, responses always ready
    a0 = 32'd10; b0 = 32'd20; v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
    exp_g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rr_ready0", {31'b0, r_rdy0}, {31'b0, ~exp_g});
      chk("t2_rr_ready1", {31'b0, r_rdy1}, {31'b0, exp_g});
      chk("t3_fp_ready1", {31'b0, p_rdy1}, 32'd0);
      cyc();
      chk("t2_rr_rsp1_valid", {31'b0, r_vld1}, {31'b0, exp_g});
      chk("t2_rr_result", r_res, exp_g ? 32'd101 : 32'd30);
      chk("t3_fp_rsp0_valid", {31'b0, p_vld0}, 32'd1);
      chk("t3_fp_result", p_res, 32'd30);
      exp_g = ~exp_g;
    end
    v0 = 1'b0; #1;
    chk("t3_fp_ready1_drop", {31'b0, p_rdy1}, 32'd1);
    chk("t3_fp_alu_a", p_alua, 32'd100);
    cyc(); v1 = 1'b0; #1;
    chk("t3_fp_rsp1_valid", {31'b0, p_vld1}, 32'd1);
    chk("t3_fp_result1", p_res, 32'd101);
    cyc(); rr0 = 1'b0; rr1 = 1'b0;

    // 4: SLTU held under back-pressure with req0 pending
    op1 = 2'b01; a1 = 32'd3; b1 = 32'd9; v1 = 1'b1; #1;
    chk("t4_ready1", {31'b0, r_rdy1}, 32'd1);
    cyc(); v1 = 1'b0; v0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_hold_valid", {31'b0, r_vld1}, 32'd1);
      chk("t4_hold_result", r_res, 32'd1);
      chk("t4_ready0", {31'b0, r_rdy0}, 32'd0);
      chk("t4_ready1", {31'b0, r_rdy1}, 32'd0);
      cyc();
    end
    rr1 = 1'b1; #1;
    chk("t4_resume_ready0", {31'b0, r_rdy0}, 32'd1);
    cyc(); v0 = 1'b0; rr1 = 1'b0; #1;
    chk("t4_rsp0_valid", {31'b0, r_vld0}, 32'd1);
    chk("t4_rsp1_valid", {31'b0, r_vld1}, 32'd0);
    chk("t4_result", r_res, 32'd30);
    rr0 = 1'b1;
    cyc(); rr0 = 1'b0;

    // 5: funct-mode add wraps
    op0 = 2'b10; f0 = 4'b0000; a0 = 32'hFFFF_FFFF; b0 = 32'd1; v0 = 1'b1; #1;
    chk("t5_alu_aluop", {30'b0, r_aluop}, 32'd2);
    cyc(); v0 = 1'b0; #1;
    chk("t5_rsp0_valid", {31'b0, r_vld0}, 32'd1);
    chk("t5_result", r_res, 32'd0);
    rr0 = 1'b1;
    cyc(); rr0 = 1'b0; #1;
    chk("t5_idle_aluop", {30'b0, r_aluop}, 32'd0);
    chk("t5_idle_funct", {28'b0, r_alufn}, 32'd0);
    chk("t5_idle_a", r_alua, 32'd0);
    chk("t5_idle_b", r_alub, 32'd0);

    // 6: reset while a result is held
    op0 = 2'b00; a0 = 32'd5; b0 = 32'd7; v0 = 1'b1;
    cyc(); v0 = 1'b0; #1;
    chk("t6_pre_valid", {31'b0, r_vld0}, 32'd1);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("t6_rsp0_valid", {31'b0, r_vld0}, 32'd0);
    chk("t6_result", r_res, 32'd0);
    a0 = 32'd10; b0 = 32'd20; a1 = 32'd100; b1 = 32'd1; op1 = 2'b00;
    v0 = 1'b1; v1 = 1'b1; #1;
    chk("t6_first_ready0", {31'b0, r_rdy0}, 32'd1);
    chk("t6_first_ready1", {31'b0, r_rdy1}, 32'd0);
    cyc(); v0 = 1'b0; v1 = 1'b0; #1;
    chk("t6_rsp0_valid2", {31'b0, r_vld0}, 32'd1);
    chk("t6_result2", r_res, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
